// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle RV32I control FSM with retire counter
module unidad_control_multiciclo #(
  parameter int ANCHO_CNT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          instruccion_i,
  input  logic                 cero_i,
  input  logic                 mem_listo_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 iord_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 reg_we_o,
  output logic [1:0]           alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic [1:0]           resultado_sel_o,
  output logic [2:0]           tipo_imm_o,
  output logic                 instr_ilegal_o,
  output logic [3:0]           estado_o,
  output logic [ANCHO_CNT-1:0] instr_retiradas_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    TRAP      = 4'd11
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  estado_t              estado;
  logic [ANCHO_CNT-1:0] retiradas;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       es_r, es_i, es_load, es_store, es_branch_op, es_branch, es_jal;
  logic       retira;
  logic       unused_bits;

  assign opcode       = instruccion_i[6:0];
  assign funct3       = instruccion_i[14:12];
  assign unused_bits  = ^{instruccion_i[31:15], instruccion_i[11:7]};

  assign es_r         = (opcode == OP_R);
  assign es_i         = (opcode == OP_I);
  assign es_load      = (opcode == OP_LOAD);
  assign es_store     = (opcode == OP_STORE);
  assign es_branch_op = (opcode == OP_BRANCH);
  // Only beq/bne are implemented; other branch flavours are treated as illegal
  assign es_branch    = es_branch_op && (funct3 == 3'b000 || funct3 == 3'b001);
  assign es_jal       = (opcode == OP_JAL);

  // An instruction retires on the edge that leaves its last state
  assign retira = (estado == ALU_WB) || (estado == MEM_WB) || (estado == BRANCH) ||
                  ((estado == MEM_WRITE) && mem_listo_i);

  // State sequencing and retired-instruction counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      estado    <= FETCH;
      retiradas <= '0;
    end else begin
      if (retira) retiradas <= retiradas + ANCHO_CNT'(1);
      case (estado)
        FETCH:     if (mem_listo_i) estado <= DECODE;
        DECODE: begin
          if (es_load || es_store) estado <= MEM_ADDR;
          else if (es_r)           estado <= EXEC_R;
          else if (es_i)           estado <= EXEC_I;
          else if (es_branch)      estado <= BRANCH;
          else if (es_jal)         estado <= JAL;
          else                     estado <= TRAP;
        end
        MEM_ADDR:  estado <= es_store ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (mem_listo_i) estado <= MEM_WB;
        MEM_WB:    estado <= FETCH;
        MEM_WRITE: if (mem_listo_i) estado <= FETCH;
        EXEC_R:    estado <= ALU_WB;
        EXEC_I:    estado <= ALU_WB;
        ALU_WB:    estado <= FETCH;
        BRANCH:    estado <= FETCH;
        JAL:       estado <= ALU_WB;
        TRAP:      estado <= TRAP;
        default:   estado <= FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state (plus handshake/zero flag)
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    iord_o          = 1'b0;
    ir_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    reg_we_o        = 1'b0;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    resultado_sel_o = 2'b00;
    tipo_imm_o      = 3'b000;
    instr_ilegal_o  = 1'b0;
    case (estado)
      FETCH: begin
        mem_req_o       = 1'b1;
        alu_src_b_o     = 2'b10;
        resultado_sel_o = 2'b10;
        ir_we_o         = mem_listo_i;
        pc_we_o         = mem_listo_i;
      end
      DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        if (es_branch_op)  tipo_imm_o = 3'b011;
        else if (es_jal)   tipo_imm_o = 3'b100;
        else               tipo_imm_o = 3'b001;
      end
      MEM_ADDR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        tipo_imm_o  = es_store ? 3'b010 : 3'b001;
      end
      MEM_READ: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEM_WB: begin
        reg_we_o        = 1'b1;
        resultado_sel_o = 2'b01;
      end
      MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        tipo_imm_o  = 3'b001;
      end
      ALU_WB: begin
        reg_we_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_we_o     = funct3[0] ? ~cero_i : cero_i;
      end
      JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_we_o     = 1'b1;
      end
      TRAP: begin
        instr_ilegal_o = 1'b1;
      end
      default: begin
        instr_ilegal_o = 1'b0;
      end
    endcase
  end

  assign estado_o          = estado;
  assign instr_retiradas_o = retiradas;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - self-checking bench for the multicycle controller
module tb_unidad_control_multiciclo;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3;
  localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] instruccion_i;
  logic        cero_i;
  logic        mem_listo_i;

  logic        mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, reg_we_o, instr_ilegal_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, resultado_sel_o;
  logic [2:0]  tipo_imm_o;
  logic [3:0]  estado_o;
  logic [31:0] instr_retiradas_o;

  logic        mem_req_4, mem_we_4, iord_4, ir_we_4, pc_we_4, reg_we_4, instr_ilegal_4;
  logic [1:0]  alu_src_a_4, alu_src_b_4, alu_op_4, resultado_sel_4;
  logic [2:0]  tipo_imm_4;
  logic [3:0]  estado_4;
  logic [3:0]  instr_retiradas_4;

  int errors = 0;
  int checks = 0;
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.ANCHO_CNT(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .instruccion_i(instruccion_i), .cero_i(cero_i),
    .mem_listo_i(mem_listo_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .reg_we_o(reg_we_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .resultado_sel_o(resultado_sel_o),
    .tipo_imm_o(tipo_imm_o), .instr_ilegal_o(instr_ilegal_o), .estado_o(estado_o),
    .instr_retiradas_o(instr_retiradas_o)
  );

  unidad_control_multiciclo #(.ANCHO_CNT(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .instruccion_i(instruccion_i), .cero_i(cero_i),
    .mem_listo_i(mem_listo_i), .mem_req_o(mem_req_4), .mem_we_o(mem_we_4), .iord_o(iord_4),
    .ir_we_o(ir_we_4), .pc_we_o(pc_we_4), .reg_we_o(reg_we_4), .alu_src_a_o(alu_src_a_4),
    .alu_src_b_o(alu_src_b_4), .alu_op_o(alu_op_4), .resultado_sel_o(resultado_sel_4),
    .tipo_imm_o(tipo_imm_4), .instr_ilegal_o(instr_ilegal_4), .estado_o(estado_4),
    .instr_retiradas_o(instr_retiradas_4)
  );

  typedef struct {
    logic [31:0] ins;
    int          wf;
    int          wd;
    logic        cero;
    int          exp_len;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_ctrl();
    return {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, reg_we_o, alu_src_a_o,
            alu_src_b_o, alu_op_o, resultado_sel_o, tipo_imm_o, instr_ilegal_o};
  endfunction

  function automatic logic [17:0] dut4_ctrl();
    return {mem_req_4, mem_we_4, iord_4, ir_we_4, pc_we_4, reg_we_4, alu_src_a_4,
            alu_src_b_4, alu_op_4, resultado_sel_4, tipo_imm_4, instr_ilegal_4};
  endfunction

  // Control word each state must present, taken from the per-state output table
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [31:0] ins,
                                           input logic listo, input logic cero);
    logic mreq, mwe, io, irwe, pcwe, rwe, il;
    logic [1:0] a, b, op, rs;
    logic [2:0] t;
    {mreq, mwe, io, irwe, pcwe, rwe, il} = 7'b0;
    {a, b, op, rs} = 8'b0;
    t = 3'b000;
    case (st)
      S_FETCH:     begin mreq = 1; b = 2; rs = 2; irwe = listo; pcwe = listo; end
      S_DECODE:    begin a = 1; b = 1;
                     t = (ins[6:0] == 7'b1100011) ? 3'd3 : (ins[6:0] == 7'b1101111) ? 3'd4 : 3'd1; end
      S_MEM_ADDR:  begin a = 2; b = 1; t = (ins[6:0] == 7'b0100011) ? 3'd2 : 3'd1; end
      S_MEM_READ:  begin mreq = 1; io = 1; end
      S_MEM_WB:    begin rwe = 1; rs = 1; end
      S_MEM_WRITE: begin mreq = 1; mwe = 1; io = 1; end
      S_EXEC_R:    begin a = 2; op = 2; end
      S_EXEC_I:    begin a = 2; b = 1; op = 2; t = 1; end
      S_ALU_WB:    begin rwe = 1; end
      S_BRANCH:    begin a = 2; op = 1; pcwe = (ins[14:12] == 3'b001) ? ~cero : cero; end
      S_JAL:       begin a = 1; b = 2; pcwe = 1; end
      S_TRAP:      begin il = 1; end
      default:     begin il = 0; end
    endcase
    return {mreq, mwe, io, irwe, pcwe, rwe, a, b, op, rs, t, il};
  endfunction

  // 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jal, 6 illegal
  function automatic int clase(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return (ins[14:13] == 2'b00) ? 4 : 6;
      7'b1101111: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: begin r[6:0] = 7'b1100011; r[14:13] = 2'b00; end
      default: r[6:0] = 7'b1101111;
    endcase
    return r;
  endfunction

  // Called at posedge+1; asynchronous reset checked without any clock edge
  task automatic do_reset();
    mem_listo_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("rst_estado", estado_o, S_FETCH);
    chk("rst_ctrl", dut_ctrl(), exp_ctrl(S_FETCH, 32'h0, 1'b0, 1'b0));
    chk("rst_cnt", instr_retiradas_o, 0);
    chk("rst_cnt4", {estado_4, instr_retiradas_4}, 8'h00);
    cnt = 0;
    rst_ni = 1'b1;
  endtask

  // Runs one instruction from FETCH with the given wait states and checks every cycle
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wd,
                           input logic cero, input int exp_len);
    logic [3:0] q[$];
    logic       lq[$];
    int         c;
    int         lat;
    c = clase(ins);
    for (int k = 0; k <= wf; k++) begin q.push_back(S_FETCH); lq.push_back(k == wf); end
    q.push_back(S_DECODE); lq.push_back(1'($urandom));
    case (c)
      0: begin q.push_back(S_EXEC_R); q.push_back(S_ALU_WB); lq.push_back(1'($urandom)); lq.push_back(1'($urandom)); end
      1: begin q.push_back(S_EXEC_I); q.push_back(S_ALU_WB); lq.push_back(1'($urandom)); lq.push_back(1'($urandom)); end
      2: begin
        q.push_back(S_MEM_ADDR); lq.push_back(1'($urandom));
        for (int k = 0; k <= wd; k++) begin q.push_back(S_MEM_READ); lq.push_back(k == wd); end
        q.push_back(S_MEM_WB); lq.push_back(1'($urandom));
      end
      3: begin
        q.push_back(S_MEM_ADDR); lq.push_back(1'($urandom));
        for (int k = 0; k <= wd; k++) begin q.push_back(S_MEM_WRITE); lq.push_back(k == wd); end
      end
      4: begin q.push_back(S_BRANCH); lq.push_back(1'($urandom)); end
      5: begin q.push_back(S_JAL); q.push_back(S_ALU_WB); lq.push_back(1'($urandom)); lq.push_back(1'($urandom)); end
      default: for (int k = 0; k < 3; k++) begin q.push_back(S_TRAP); lq.push_back(1'b1); end
    endcase
    lat = wf + 1;
    for (int i = 0; i < q.size(); i++) begin
      instruccion_i = (q[i] == S_FETCH) ? $urandom : ins;
      mem_listo_i   = lq[i];
      cero_i        = (q[i] == S_BRANCH) ? cero : 1'($urandom);
      @(negedge clk);
      chk("estado", estado_o, q[i]);
      chk("ctrl", dut_ctrl(), exp_ctrl(q[i], instruccion_i, mem_listo_i, cero_i));
      if (estado_o != S_FETCH) lat++;
      @(posedge clk);
      #1;
    end
    if (c != 6) cnt++;
    chk("fin_estado", estado_o, (c == 6) ? S_TRAP : S_FETCH);
    chk("cnt", instr_retiradas_o, cnt);
    chk("cnt4", instr_retiradas_4, cnt % 16);
    if (exp_len > 0) chk("latencia", lat, exp_len);
  endtask

  initial begin
    rst_ni = 1'b0;
    instruccion_i = 32'h0;
    cero_i = 1'b0;
    mem_listo_i = 1'b1;

    tbl[0] = '{32'h002081B3, 0, 0, 1'b0, 4};   // add x3,x1,x2
    tbl[1] = '{32'h00802283, 0, 2, 1'b0, 7};   // lw x5,8(x0), two data waits
    tbl[2] = '{32'h00208063, 0, 0, 1'b1, 3};   // beq taken
    tbl[3] = '{32'h00208063, 0, 0, 1'b0, 3};   // beq not taken
    tbl[4] = '{32'h00209063, 0, 0, 1'b0, 3};   // bne taken
    tbl[5] = '{32'h010000EF, 0, 0, 1'b0, 4};   // jal x1,16
    tbl[6] = '{32'h0020A223, 1, 1, 1'b0, 6};   // sw with fetch and data waits
    tbl[7] = '{32'h00500093, 2, 0, 1'b0, 6};   // addi with two fetch waits
    tbl[8] = '{32'h0000007F, 0, 0, 1'b0, 5};   // illegal opcode
    tbl[9] = '{32'h0020A063, 0, 0, 1'b0, 5};   // branch funct3=010 is illegal

    @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req_o, 1'b1);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].ins, tbl[i].wf, tbl[i].wd, tbl[i].cero, tbl[i].exp_len);
      if (clase(tbl[i].ins) == 6) begin
        chk("trap_flag", instr_ilegal_o, 1'b1);
        do_reset();
        chk("trap_flag_clr", instr_ilegal_o, 1'b0);
      end
    end

    // Reset in the middle of a store abandons the write immediately
    run_instr(32'h002081B3, 0, 0, 1'b0, 4);
    instruccion_i = 32'h0020A223;
    mem_listo_i = 1'b1;
    @(posedge clk); #1;          // leave FETCH
    @(posedge clk); #1;          // DECODE -> MEM_ADDR
    @(posedge clk); #1;          // MEM_ADDR -> MEM_WRITE
    mem_listo_i = 1'b0;
    @(negedge clk);
    chk("mw_estado", estado_o, S_MEM_WRITE);
    chk("mw_we", mem_we_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mw_rst_estado", estado_o, S_FETCH);
    chk("mw_rst_we", mem_we_o, 1'b0);
    chk("mw_rst_req", mem_req_o, 1'b1);
    chk("mw_rst_cnt", instr_retiradas_o, 0);
    @(posedge clk); #1;
    do_reset();

    // Narrow counter wraps: 17 retirements read back as 1
    for (int i = 0; i < 17; i++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), -1);
    chk("wrap4", instr_retiradas_4, 4'd1);
    chk("wrap32", instr_retiradas_o, 17);

    for (int i = 0; i < 40; i++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
    chk("ctrl4_eq", dut4_ctrl(), dut_ctrl());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Moore-style finite-state controller that sequences the multicycle RV32I datapath: instruction fetch over a ready-handshaked memory port, decode, execute, memory access and register write-back. It drives every datapath mux and write enable. It also drives the format select of the immediate generator (I/S/B/J). It flags unsupported opcodes, halts on them, and counts retired instructions.

## Interface
- ANCHO_CNT, 32, width of the retired-instruction counter

- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- instruccion_i  in  32  contents of the instruction register (valid from DECODE on)
- cero_i  in  1  ALU zero flag, combinational from the current ALU operands
- mem_listo_i  in  1  memory ready; completes the access requested this cycle
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  memory write (qualifies mem_req_o)
- iord_o  out  1  address select: 0 = PC, 1 = ALU-out register
- ir_we_o  out  1  instruction register / old-PC register load
- pc_we_o  out  1  PC load from result mux
- reg_we_o  out  1  register-file write of rd from result mux
- alu_src_a_o  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b_o  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op_o  out  2  00 add, 01 sub, 10 decoded from funct3/funct7
- resultado_sel_o  out  2  00 ALU-out register, 01 memory data register, 10 ALU combinational
- tipo_imm_o  out  3  000 none, 001 I, 010 S, 011 B, 100 J
- instr_ilegal_o  out  1  sticky illegal-instruction flag
- estado_o  out  4  current state encoding
- instr_retiradas_o  out  ANCHO_CNT  retired-instruction count

## Operation
- Opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch (funct3 000 beq, 001 bne), 1101111 jal. Any other opcode, or a branch with another funct3, is illegal.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, TRAP=11.
- All outputs not listed for a state are 0.
- FETCH
  - Outputs: mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00, resultado_sel=10.
  - If mem_listo_i=1: ir_we=1 and pc_we=1 (PC←PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00. tipo_imm is B for a branch, J for jal, otherwise I. This precomputes the branch/jump target into ALU-out.
  - Next state: load/store→MEM_ADDR, R→EXEC_R, I-ALU→EXEC_I, branch→BRANCH, jal→JAL, illegal→TRAP.
- MEM_ADDR
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00. tipo_imm is S for a store, I for a load.
  - Next state: MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ
  - Outputs: mem_req=1, iord=1.
  - Next state: MEM_WB on mem_listo_i, else stay.
- MEM_WB
  - Outputs: reg_we=1, resultado_sel=01.
  - Next state: FETCH.
- MEM_WRITE
  - Outputs: mem_req=1, mem_we=1, iord=1.
  - Next state: FETCH on mem_listo_i, else stay.
- EXEC_R
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next state: ALU_WB.
- EXEC_I
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=10, tipo_imm=001.
  - Next state: ALU_WB.
- ALU_WB
  - Outputs: reg_we=1, resultado_sel=00.
  - Next state: FETCH.
- BRANCH
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, resultado_sel=00.
  - pc_we is cero_i for beq and ~cero_i for bne.
  - Next state: FETCH.
- JAL
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, resultado_sel=00, pc_we=1. This sets PC←target and ALU-out←old PC+4.
  - Next state: ALU_WB, which writes rd.
- TRAP
  - instr_ilegal_o=1 and all enables 0.
  - Stays in TRAP until reset.
- Retire counter
  - Increments by 1 on the clock edge that leaves ALU_WB, MEM_WB, BRANCH, or MEM_WRITE with mem_listo_i=1.
  - Wraps modulo 2^ANCHO_CNT.
  - Never increments in TRAP.

## Timing
- Reset (rst_ni=0, asynchronous): state=FETCH, instr_retiradas_o=0, instr_ilegal_o=0.
  - All outputs take their FETCH values immediately, so mem_req_o=1 while in reset.
  - Reset mid-access abandons the access. There is no pending-write completion.
- Every state lasts one cycle, except FETCH/MEM_READ/MEM_WRITE, which add one cycle per cycle with mem_listo_i=0.
- Latency in cycles with zero wait states: beq/bne 3, R 4, I 4, store 4, jal 4, load 5.
- Memory handshake
  - The access completes on the edge where mem_req_o=1 and mem_listo_i=1.
  - mem_listo_i is ignored whenever mem_req_o=0.
  - mem_we_o and iord_o stay stable while mem_req_o is held.
- Outputs depend only on state and instruccion_i, except pc_we/ir_we (mem_listo_i) and BRANCH pc_we (cero_i).

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with mem_listo_i always 1 → states 0,1,6,8,0. reg_we=1 only in state 8. Counter 0→1.
- lw x5,8(x0) (0x00802283) with mem_listo_i low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. iord=1 in state 3. resultado_sel=01 in state 4.
- beq taken (cero_i=1) vs not taken (cero_i=0) → pc_we=1/0 in BRANCH. Both take 3 cycles, and the counter increments in both cases.
- jal x1,16 (0x010000EF) → tipo_imm=100 in DECODE. pc_we=1 in JAL. reg_we=1 in the following ALU_WB.
- Opcode 0x0000007F → TRAP after DECODE. instr_ilegal_o=1 and stays 1. mem_req_o=0. Counter frozen. rst_ni pulse returns the controller to FETCH with the flag cleared.
- ANCHO_CNT=4: retire 17 instructions → counter reads 1.
- rst_ni asserted mid-MEM_WRITE → immediate FETCH, mem_we_o=0 without waiting for a clock edge.
